// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin, packet-locking arbiter that shares the single write port of a
// synchronous FIFO among NUM_REQ requesters. One requester is selected in IDLE.
// The grant is then held in LOCK until that requester's packet completes. FIFO
// full back-pressures the granted requester, and all other requesters stall.
//
// Optional feature macro: FIFO_ARB_BURST_LIMIT_EN
//   When defined, a grant is also released after MAX_BURST accepted beats.
//   The rest of the packet then re-arbitrates as a new grant.
//
// Parameters:
//   NUM_REQ    : number of requesters (>= 2)
//   DATA_WIDTH : FIFO word width
//   MAX_BURST  : beats per grant when FIFO_ARB_BURST_LIMIT_EN is defined (>= 1)
//
// Ports:
//   sys_clk      in   write-side clock
//   sys_rst      in   synchronous active-high reset
//   req_valid    in   per-requester beat valid
//   req_data     in   requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last     in   final beat of a packet (qualified by valid)
//   req_ready    out  beat accepted when req_valid[i] & req_ready[i]
//   fifo_full    in   FIFO full flag
//   fifo_wr_en   out  FIFO write enable (combinational)
//   fifo_wdata   out  FIFO write data (combinational mux on grant_id)
//   grant_id     out  index of the current / last grant holder
//   grant_active out  high while in LOCK
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 8
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            fifo_full,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_wdata,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            grant_active
);

    localparam int IDW = $clog2(NUM_REQ);

    // Reject illegal configurations at elaboration time.
    if (NUM_REQ < 2 || MAX_BURST < 1) begin : g_param_check
        $fatal(1, "fifo_wr_arbiter: NUM_REQ must be >= 2 and MAX_BURST >= 1");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t             r_state;
    logic [IDW-1:0]     r_grant_id;
    logic [IDW-1:0]     r_rr_ptr;

    logic               w_found;
    logic [IDW-1:0]     w_winner;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic               w_locked;
    logic               w_accept;
    logic               w_release;
    logic [IDW-1:0]     w_next_ptr;

`ifdef FIFO_ARB_BURST_LIMIT_EN
    localparam int CNTW = $clog2(MAX_BURST + 1);
    logic [CNTW-1:0]    r_beat_cnt;
    logic               w_burst_done;
`endif

    // Round-robin winner search: first pass takes the lowest valid index at or
    // above rr_ptr; if none, the second pass takes the lowest valid index
    // overall, which is the wrap-around case.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[i] && (IDW'(i) >= r_rr_ptr)) begin
                w_found  = 1'b1;
                w_winner = IDW'(i);
            end else begin
                w_found  = w_found;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[i]) begin
                w_found  = 1'b1;
                w_winner = IDW'(i);
            end else begin
                w_found  = w_found;
            end
        end
    end

    // Select the granted requester's valid, last and data.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == IDW'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
                w_sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                w_sel_valid = w_sel_valid;
            end
        end
    end

    assign w_locked   = (r_state == ST_LOCK);
    assign w_accept   = w_locked & w_sel_valid & ~fifo_full;
    assign w_next_ptr = (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : (r_grant_id + 1'b1);

`ifdef FIFO_ARB_BURST_LIMIT_EN
    // The beat that brings the count to MAX_BURST ends the grant.
    assign w_burst_done = (r_beat_cnt == CNTW'(MAX_BURST - 1));
    assign w_release    = w_accept & (w_sel_last | w_burst_done);
`else
    assign w_release    = w_accept & w_sel_last;
`endif

    // Ready goes only to the grant holder, and only while the FIFO has room.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_locked && !fifo_full && (r_grant_id == IDW'(i))) begin
                req_ready[i] = 1'b1;
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    assign fifo_wr_en   = w_accept;
    assign fifo_wdata   = w_sel_data;
    assign grant_id     = r_grant_id;
    assign grant_active = w_locked;

    // Arbitration FSM: IDLE picks a winner, and LOCK holds it until release.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= ST_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
`ifdef FIFO_ARB_BURST_LIMIT_EN
            r_beat_cnt <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_winner;
                        r_state    <= ST_LOCK;
`ifdef FIFO_ARB_BURST_LIMIT_EN
                        r_beat_cnt <= '0;
`endif
                    end else begin
                        r_state    <= ST_IDLE;
                    end
                end
                ST_LOCK: begin
                    if (w_release) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end else begin
                        r_state  <= ST_LOCK;
                    end
`ifdef FIFO_ARB_BURST_LIMIT_EN
                    if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end else begin
                        r_beat_cnt <= r_beat_cnt;
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed testbench for fifo_wr_arbiter. Each requester has a packet queue,
// and a beat leaves the queue when it is handshaken. A behavioural model of the
// arbitration rules tracks the owner, the round-robin pointer and the beat
// count. It checks every DUT output on every falling edge. The words written to
// the FIFO are captured and compared with hand-written expected sequences.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 8;
`ifdef FIFO_ARB_BURST_LIMIT_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_wdata;
    logic [1:0]        grant_id;
    logic              grant_active;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .sys_clk      (clk),
        .sys_rst      (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wdata   (fifo_wdata),
        .grant_id     (grant_id),
        .grant_active (grant_active)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [8:0] txq [N][$];
    bit [N-1:0] pause;
    bit         full_in;
    logic [N-1:0] acc;
    int         cap_data[$];
    int         cap_cyc[$];
    int         expq[$];
    int         cyc;
    bit         check_en;

    int m_owner;
    int m_grant;
    int m_ptr;
    int m_beats;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model and per-cycle compare, sampled on the falling edge.
    initial begin : chk
        logic [N-1:0] exp_ready;
        bit           exp_wr;
        bit           exp_active;
        int           w;
        m_owner = -1; m_grant = 0; m_ptr = 0; m_beats = 0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            exp_active = (m_owner >= 0);
            exp_ready  = '0;
            exp_wr     = 1'b0;
            if (m_owner >= 0) begin
                exp_ready[m_owner] = !fifo_full;
                exp_wr = req_valid[m_owner] && !fifo_full;
            end
            if (check_en) begin
                check("cyc_req_ready", 32'(req_ready), 32'(exp_ready));
                check("cyc_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
                check("cyc_active", 32'(grant_active), 32'(exp_active));
                check("cyc_grant_id", 32'(grant_id), 32'(m_grant));
                if (exp_wr) check("cyc_wdata", 32'(fifo_wdata), 32'(req_data[m_owner*DW +: DW]));
            end
            acc = req_valid & req_ready;
            if (fifo_wr_en === 1'b1) begin
                cap_data.push_back(int'(fifo_wdata));
                cap_cyc.push_back(cyc);
            end
            // Advance the model to the state the DUT must hold after the next edge.
            if (rst) begin
                m_owner = -1; m_grant = 0; m_ptr = 0; m_beats = 0;
            end else if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    w = (m_ptr + k) % N;
                    if (m_owner < 0 && req_valid[w]) begin
                        m_owner = w; m_grant = w; m_beats = 0;
                    end
                end
            end else if (exp_wr) begin
                m_beats++;
                if (req_last[m_owner] || (BURST_EN && m_beats == MB)) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end
    end

    task automatic apply();
        logic [8:0] b;
        for (int i = 0; i < N; i++) begin
            if (!pause[i] && txq[i].size() > 0) begin
                b = txq[i][0];
                req_valid[i] = 1'b1;
                req_last[i]  = b[8];
                req_data[i*DW +: DW] = b[7:0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
                req_data[i*DW +: DW] = 8'h00;
            end
        end
        fifo_full = full_in;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && txq[i].size() > 0) void'(txq[i].pop_front());
        end
        apply();
    endtask

    task automatic push_pkt(input int i, input int n, input int base, input int step);
        logic [7:0] d;
        for (int k = 0; k < n; k++) begin
            d = 8'(base + k * step);
            txq[i].push_back({(k == n - 1), d});
        end
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < N; i++) if (txq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic drain(input string name);
        int budget = 0;
        while (!(all_empty() && m_owner < 0) && budget < 300) begin
            tick();
            budget++;
        end
        check({name, "_drain_in_time"}, 32'(budget < 300), 32'd1);
    endtask

    task automatic wait_cap(input int n, input string name);
        int budget = 0;
        while (cap_data.size() < n && budget < 100) begin
            tick();
            budget++;
        end
        check({name, "_cap_in_time"}, 32'(budget < 100), 32'd1);
    endtask

    task automatic wait_grant(input int g, input string name);
        int budget = 0;
        while (!(grant_active === 1'b1 && grant_id === 2'(g)) && budget < 100) begin
            tick();
            budget++;
        end
        check({name, "_grant_in_time"}, 32'(budget < 100), 32'd1);
    endtask

    task automatic check_cap(input string name);
        int n;
        check({name, "_count"}, 32'(cap_data.size()), 32'(expq.size()));
        n = (cap_data.size() < expq.size()) ? cap_data.size() : expq.size();
        for (int k = 0; k < n; k++) check({name, "_word"}, 32'(cap_data[k]), 32'(expq[k]));
    endtask

    task automatic clear_cap();
        cap_data.delete();
        cap_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; full_in = 1'b0; pause = '0; check_en = 1'b0; acc = '0;
        req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;

        // Reset with every requester valid; each queues two 2-beat packets.
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++) push_pkt(i, 2, 8'hA0 + i, 0);
        apply();
        tick();
        check_en = 1'b1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        check("rst_active", 32'(grant_active), 32'h0);
        tick();
        check("rst2_ready", 32'(req_ready), 32'h0);
        check("rst2_active", 32'(grant_active), 32'h0);
        clear_cap();
        rst = 1'b0;
        apply();
        tick();
        check("first_grant_id", 32'(grant_id), 32'h0);
        check("first_grant_active", 32'(grant_active), 32'h1);

        // Round-robin: order 0,1,2,3,0,1,2,3, one idle cycle between packets.
        drain("rr");
        expq = '{8'hA0, 8'hA0, 8'hA1, 8'hA1, 8'hA2, 8'hA2, 8'hA3, 8'hA3,
                 8'hA0, 8'hA0, 8'hA1, 8'hA1, 8'hA2, 8'hA2, 8'hA3, 8'hA3};
        check_cap("rr");
        if (cap_cyc.size() == 16)
            for (int k = 1; k < 16; k++)
                check("rr_gap", 32'(cap_cyc[k] - cap_cyc[0]), 32'(k + k / 2));

        // Backpressure: FIFO full for 3 cycles after beat 2 of requester 2.
        clear_cap();
        push_pkt(2, 4, 8'h11, 1);
        apply();
        wait_cap(2, "bp");
        for (int c = 0; c < 3; c++) begin
            full_in = 1'b1;
            apply();
            #1;
            check("bp_ready2", 32'(req_ready[2]), 32'h0);
            check("bp_no_write", 32'(fifo_wr_en), 32'h0);
            tick();
        end
        full_in = 1'b0;
        apply();
        drain("bp");
        expq = '{8'h11, 8'h12, 8'h13, 8'h14};
        check_cap("bp");

        // Lock hold: requester 1 pauses mid-packet while requester 3 waits.
        clear_cap();
        push_pkt(1, 4, 8'h21, 1);
        apply();
        wait_grant(1, "lock");
        push_pkt(3, 2, 8'h31, 1);
        apply();
        wait_cap(2, "lock");
        pause[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            apply();
            #1;
            check("lock_grant_id", 32'(grant_id), 32'h1);
            check("lock_ready3", 32'(req_ready[3]), 32'h0);
            check("lock_active", 32'(grant_active), 32'h1);
            tick();
        end
        pause[1] = 1'b0;
        apply();
        drain("lock");
        expq = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h31, 8'h32};
        check_cap("lock");

        // Reset during beat 2 of a 4-beat packet from requester 3.
        clear_cap();
        push_pkt(3, 4, 8'h41, 1);
        apply();
        wait_grant(3, "mrst");
        wait_cap(1, "mrst");
        rst = 1'b1;
        push_pkt(0, 1, 8'h51, 1);
        apply();
        tick();
        rst = 1'b0;
        apply();
        check("mrst_idle", 32'(grant_active), 32'h0);
        check("mrst_grant_id", 32'(grant_id), 32'h0);
        tick();
        check("mrst_winner", 32'(grant_id), 32'h0);
        check("mrst_winner_active", 32'(grant_active), 32'h1);
        drain("mrst");
        expq = '{8'h41, 8'h42, 8'h51, 8'h43, 8'h44};
        check_cap("mrst");

        // Long packet from requester 0 with requester 1 waiting.
        clear_cap();
        push_pkt(0, 12, 8'h60, 1);
        apply();
        tick();
        check("burst_grant0", 32'(grant_id), 32'h0);
        push_pkt(1, 2, 8'h71, 1);
        apply();
        drain("burst");
        if (BURST_EN)
            expq = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67,
                     8'h71, 8'h72, 8'h68, 8'h69, 8'h6A, 8'h6B};
        else
            expq = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67,
                     8'h68, 8'h69, 8'h6A, 8'h6B, 8'h71, 8'h72};
        check_cap("burst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
